preg_free_list: RTL and testbench
=================================

Name: preg_free_list

Overview:
- Tracks which physical registers are free and hands out register indices to the rename stage.
- Sits directly upstream of the physical register file:
  - each granted alloc_index becomes the write address that register's producer later uses on the register file write port;
  - commit/squash logic returns indices through the free port.
- Also supports a single-cycle wholesale restore of the free mask on misspeculation recovery.

Parameters:
- NSLOTS, 4, number of physical registers tracked; must match the register file's nregs.
- NUM_RESERVED, 0, slots 0..NUM_RESERVED-1 come out of reset allocated (architectural mappings); 0 <= NUM_RESERVED <= NSLOTS.
- FREE_BYPASS, 1, when 1 a same-cycle free makes its index visible to alloc in that cycle.
- Derived: IW = clog2(NSLOTS), CW = clog2(NSLOTS+1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- alloc_call  in  1  consume one free slot this cycle; legal only when alloc_rdy=1
- alloc_rdy  out  1  at least one slot is grantable this cycle
- alloc_index  out  IW  index granted if alloc_call; valid whenever alloc_rdy=1
- free_call  in  1  return a slot this cycle
- free_index  in  IW  slot being returned
- restore_call  in  1  overwrite the free mask next cycle
- restore_mask  in  NSLOTS  new free mask (bit=1 means free)
- free_mask  out  NSLOTS  current registered free mask
- free_count  out  CW  popcount of free_mask, registered

Behaviour:
- State:
  - mask[NSLOTS-1:0], 1=free.
  - count[CW-1:0], maintained incrementally (no popcount tree on the output path).
- Reset (clk edge with reset=1):
  - mask = ones with bits 0..NUM_RESERVED-1 cleared; count = NSLOTS-NUM_RESERVED.
  - alloc/free/restore are ignored in that cycle.
- Effective mask (combinational):
  - eff = mask | (FREE_BYPASS && free_call ? onehot(free_index) : 0).
  - alloc_rdy = |eff.
  - alloc_index = lowest set bit of eff; 0 when eff==0.
- Next state with reset=0 and restore_call=0:
  - the freed bit is set first, then the allocated bit is cleared.
  - mask_next = (mask | fr) & ~al, where:
    - fr = free_call ? onehot(free_index) : 0;
    - al = (alloc_call && alloc_rdy) ? onehot(alloc_index) : 0.
  - count_next = count + (fr sets a bit that was 0) - (al nonzero).
- Simultaneous alloc+free:
  - With FREE_BYPASS=1 and mask empty, the freed index is granted the same cycle; it ends allocated and count is unchanged.
  - With FREE_BYPASS=0, alloc sees only the registered mask. A freed slot becomes grantable the following cycle.
- Freeing an already-free slot: no effect on mask or count (idempotent). No error is raised.
- free_index >= NSLOTS: ignored.
- alloc_call with alloc_rdy=0: ignored, no state change. Protocol violation; the bench asserts it never occurs.
- Restore (restore_call=1, reset=0):
  - mask_next = restore_mask; count_next = popcount(restore_mask).
  - alloc and free in the same cycle are dropped. The caller stalls rename and commit during recovery.
  - alloc_rdy and alloc_index still reflect the pre-restore eff; a grant made that cycle is not honoured.
- Priority: reset > restore > free/alloc.
- Latency: a grant is combinational with alloc_call. The mask update is visible on free_mask one cycle after the call edge.
- Outputs: free_mask and free_count are pure registers; alloc_rdy and alloc_index are combinational from mask and the free port.

Decomposition:
- Shared package: NSLOTS-derived IW/CW width helpers, and a preg_index_t typedef shared with the register file address ports and the rename table.
- One natural sub-module: prio_encoder_lsb (NSLOTS-wide lowest-set-bit finder, outputs any and index). It is reusable by the issue queue's select logic.

Test Plan:
- NSLOTS=4, NUM_RESERVED=0; reset, then alloc_call 4 consecutive cycles -> alloc_index 0,1,2,3; free_count 3,2,1,0; then alloc_rdy=0.
- NUM_RESERVED=2 reset -> free_mask=4'b1100, free_count=2, first alloc_index=2.
- Empty mask, FREE_BYPASS=1, free_call idx=1 with alloc_call -> alloc_rdy=1, alloc_index=1; next cycle free_mask=0000, count=0. Repeat with FREE_BYPASS=0 -> alloc_rdy=0 that cycle; next cycle mask=0010.
- Double free of idx 3 over two cycles from mask 0000 -> mask 1000, count 1 after both frees (not 2).
- restore_call with mask 1010 while alloc_call and free_call(idx0) are asserted -> next cycle free_mask=1010, free_count=2; alloc/free dropped.
- Reset asserted mid-stream after 3 allocs with simultaneous free_call -> next cycle mask=1111, count=4.

Source files
------------

// File: rtl/preg_free_list_pkg.sv
// ============================================================================
// Module      : preg_free_list_pkg
// Description : Shared widths and index type for the physical register free list.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package preg_free_list_pkg;

    localparam int c_preg_nslots = 4;

    // A one-slot list still needs a one-bit index port.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int c_preg_iw = idx_width(c_preg_nslots);

    // Shared with the register file address ports and the rename table.
    typedef logic [c_preg_iw-1:0] preg_index_t;

endpackage

`default_nettype wire

// File: rtl/preg_free_list_if.sv
// ============================================================================
// Module      : preg_free_list_if
// Description : Alloc / free / restore bundle between rename logic and free list.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface preg_free_list_if
    import preg_free_list_pkg::*;
#(
    parameter int NSLOTS = 4
);
    localparam int c_iw = idx_width(NSLOTS);
    localparam int c_cw = cnt_width(NSLOTS);

    logic              alloc_call;
    logic              alloc_rdy;
    logic [c_iw-1:0]   alloc_index;
    logic              free_call;
    logic [c_iw-1:0]   free_index;
    logic              restore_call;
    logic [NSLOTS-1:0] restore_mask;
    logic [NSLOTS-1:0] free_mask;
    logic [c_cw-1:0]   free_count;

    modport master (
        output alloc_call, free_call, free_index, restore_call, restore_mask,
        input  alloc_rdy, alloc_index, free_mask, free_count
    );

    modport slave (
        input  alloc_call, free_call, free_index, restore_call, restore_mask,
        output alloc_rdy, alloc_index, free_mask, free_count
    );

endinterface

`default_nettype wire

// File: rtl/prio_encoder_lsb.sv
// ============================================================================
// Module      : prio_encoder_lsb
// Description : Lowest-set-bit finder; reports whether any bit is set and its index.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module prio_encoder_lsb #(
    parameter int WIDTH = 4,
    parameter int IW    = 2
) (
    input  wire logic [WIDTH-1:0] i_req,
    output logic                  o_any,
    output logic [IW-1:0]         o_index
);

    // Scanning downward lets the lowest set bit win the last assignment.
    always_comb begin
        o_any   = |i_req;
        o_index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_index = IW'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/preg_free_list.sv
// ============================================================================
// Module      : preg_free_list
// Description : Physical register free list with same-cycle free bypass and restore.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module preg_free_list
    import preg_free_list_pkg::*;
#(
    parameter int NSLOTS       = 4,
    parameter int NUM_RESERVED = 0,
    parameter int FREE_BYPASS  = 1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    preg_free_list_if.slave   fl
);

    localparam int c_iw = idx_width(NSLOTS);
    localparam int c_cw = cnt_width(NSLOTS);

    // Architectural mappings occupy the low slots out of reset.
    localparam logic [NSLOTS-1:0] c_reset_mask  = ~((NSLOTS'(1) << NUM_RESERVED) - NSLOTS'(1));
    localparam logic [c_cw-1:0]   c_reset_count = c_cw'(NSLOTS - NUM_RESERVED);

    logic [NSLOTS-1:0] r_mask;
    logic [c_cw-1:0]   r_count;

    logic [NSLOTS-1:0] w_fr;
    logic [NSLOTS-1:0] w_al;
    logic [NSLOTS-1:0] w_eff;
    logic              w_any;
    logic [c_iw-1:0]   w_idx;
    logic              w_inc;
    logic              w_dec;
    logic [c_cw-1:0]   w_restore_cnt;

    // Out-of-range free indices never match a slot, so they drop out here.
    always_comb begin
        w_fr = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            w_fr[i] = fl.free_call && (fl.free_index == c_iw'(i));
        end
    end

    assign w_eff = r_mask | ((FREE_BYPASS != 0) ? w_fr : '0);

    prio_encoder_lsb #(
        .WIDTH (NSLOTS),
        .IW    (c_iw)
    ) u_prio (
        .i_req   (w_eff),
        .o_any   (w_any),
        .o_index (w_idx)
    );

    always_comb begin
        w_al = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            w_al[i] = fl.alloc_call && w_any && (w_idx == c_iw'(i));
        end
    end

    // A bypassed free consumed by the same-cycle grant nets to zero.
    assign w_inc = |(w_fr & ~r_mask);
    assign w_dec = |w_al;

    always_comb begin
        w_restore_cnt = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            w_restore_cnt = w_restore_cnt + c_cw'(fl.restore_mask[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask  <= c_reset_mask;
            r_count <= c_reset_count;
        end else if (fl.restore_call) begin
            r_mask  <= fl.restore_mask;
            r_count <= w_restore_cnt;
        end else begin
            r_mask  <= (r_mask | w_fr) & ~w_al;
            r_count <= r_count + c_cw'(w_inc) - c_cw'(w_dec);
        end
    end

    assign fl.alloc_rdy   = w_any;
    assign fl.alloc_index = w_idx;
    assign fl.free_mask   = r_mask;
    assign fl.free_count  = r_count;

endmodule

`default_nettype wire

// File: tb/tb_preg_free_list.sv
// ============================================================================
// Module      : tb_preg_free_list
// Description : Directed and random checks of three free-list configurations.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_preg_free_list;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    preg_free_list_if #(.NSLOTS(4)) if_a ();
    preg_free_list_if #(.NSLOTS(4)) if_b ();
    preg_free_list_if #(.NSLOTS(4)) if_c ();

    preg_free_list #(.NSLOTS(4), .NUM_RESERVED(0), .FREE_BYPASS(1))
        u_base  (.clk(clk), .reset(reset), .fl(if_a));
    preg_free_list #(.NSLOTS(4), .NUM_RESERVED(2), .FREE_BYPASS(1))
        u_rsv   (.clk(clk), .reset(reset), .fl(if_b));
    preg_free_list #(.NSLOTS(4), .NUM_RESERVED(0), .FREE_BYPASS(0))
        u_nobyp (.clk(clk), .reset(reset), .fl(if_c));

    int n_checks = 0;
    int n_pass   = 0;

    // Per-instance stimulus and reference state: a set of free slots.
    bit       alloc_req   [3];
    bit       free_req    [3];
    bit [1:0] free_idx    [3];
    bit       restore_req [3];
    bit [3:0] rmask       [3];
    bit       is_free     [3][4];
    int       nres        [3] = '{0, 2, 0};
    bit       byp         [3] = '{1'b1, 1'b1, 1'b0};
    logic       obs_rdy   [3];
    logic [1:0] obs_idx   [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle();
        for (int k = 0; k < 3; k++) begin
            alloc_req[k]   = 0;
            free_req[k]    = 0;
            free_idx[k]    = 0;
            restore_req[k] = 0;
            rmask[k]       = 0;
        end
    endtask

    task automatic drive();
        if_a.alloc_call = alloc_req[0]; if_a.free_call = free_req[0]; if_a.free_index = free_idx[0];
        if_a.restore_call = restore_req[0]; if_a.restore_mask = rmask[0];
        if_b.alloc_call = alloc_req[1]; if_b.free_call = free_req[1]; if_b.free_index = free_idx[1];
        if_b.restore_call = restore_req[1]; if_b.restore_mask = rmask[1];
        if_c.alloc_call = alloc_req[2]; if_c.free_call = free_req[2]; if_c.free_index = free_idx[2];
        if_c.restore_call = restore_req[2]; if_c.restore_mask = rmask[2];
    endtask

    function automatic logic [3:0] dut_mask(input int k);
        return (k == 0) ? if_a.free_mask : (k == 1) ? if_b.free_mask : if_c.free_mask;
    endfunction

    function automatic logic [2:0] dut_count(input int k);
        return (k == 0) ? if_a.free_count : (k == 1) ? if_b.free_count : if_c.free_count;
    endfunction

    // One clock: grant prediction before the edge, state comparison after it.
    task automatic step();
        bit exp_rdy [3];
        int exp_idx [3];
        logic [3:0] exp_mask;
        int exp_cnt;
        for (int k = 0; k < 3; k++) begin
            exp_rdy[k] = 0;
            exp_idx[k] = 0;
            for (int s = 0; s < 4; s++) begin
                if (!exp_rdy[k] && (is_free[k][s] ||
                    (byp[k] && free_req[k] && free_idx[k] == s))) begin
                    exp_rdy[k] = 1;
                    exp_idx[k] = s;
                end
            end
            if (!exp_rdy[k]) alloc_req[k] = 0;
        end
        drive();
        #1;
        obs_rdy[0] = if_a.alloc_rdy; obs_idx[0] = if_a.alloc_index;
        obs_rdy[1] = if_b.alloc_rdy; obs_idx[1] = if_b.alloc_index;
        obs_rdy[2] = if_c.alloc_rdy; obs_idx[2] = if_c.alloc_index;
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("dut%0d alloc_rdy", k), 32'(obs_rdy[k]), 32'(exp_rdy[k]));
                if (exp_rdy[k])
                    check($sformatf("dut%0d alloc_index", k), 32'(obs_idx[k]), 32'(exp_idx[k]));
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                for (int s = 0; s < 4; s++) is_free[k][s] = (s >= nres[k]);
            end else if (restore_req[k]) begin
                for (int s = 0; s < 4; s++) is_free[k][s] = rmask[k][s];
            end else begin
                if (free_req[k]) is_free[k][free_idx[k]] = 1;
                if (alloc_req[k] && exp_rdy[k]) is_free[k][exp_idx[k]] = 0;
            end
            exp_mask = '0;
            exp_cnt  = 0;
            for (int s = 0; s < 4; s++) begin
                exp_mask[s] = is_free[k][s];
                exp_cnt    += int'(is_free[k][s]);
            end
            check($sformatf("dut%0d free_mask", k), 32'(dut_mask(k)), 32'(exp_mask));
            check($sformatf("dut%0d free_count", k), 32'(dut_count(k)), 32'(exp_cnt));
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++)
            for (int s = 0; s < 4; s++) is_free[k][s] = 0;
        idle();
        reset = 1;
        drive();
        step();
        reset = 0;
        check("reset base mask", 32'(if_a.free_mask), 32'h0000_000f);
        check("reset base count", 32'(if_a.free_count), 32'd4);
        check("reset rsv mask", 32'(if_b.free_mask), 32'h0000_000c);
        check("reset rsv count", 32'(if_b.free_count), 32'd2);

        // Drain the base and no-bypass lists; the reserved list grants slot 2 first.
        for (int i = 0; i < 4; i++) begin
            idle();
            alloc_req[0] = 1;
            alloc_req[2] = 1;
            alloc_req[1] = (i == 0);
            step();
            check($sformatf("drain index %0d", i), 32'(obs_idx[0]), 32'(i));
            check($sformatf("drain count %0d", i), 32'(if_a.free_count), 32'(3 - i));
            if (i == 0) check("rsv first index", 32'(obs_idx[1]), 32'd2);
        end
        idle();
        drive();
        #1;
        check("empty alloc_rdy", 32'(if_a.alloc_rdy), 32'd0);

        // Same-cycle free of slot 1 with alloc, with and without bypass.
        idle();
        alloc_req[0] = 1; free_req[0] = 1; free_idx[0] = 2'd1;
        alloc_req[2] = 1; free_req[2] = 1; free_idx[2] = 2'd1;
        step();
        check("bypass rdy", 32'(obs_rdy[0]), 32'd1);
        check("bypass index", 32'(obs_idx[0]), 32'd1);
        check("bypass mask", 32'(if_a.free_mask), 32'h0);
        check("bypass count", 32'(if_a.free_count), 32'd0);
        check("nobypass rdy", 32'(obs_rdy[2]), 32'd0);
        check("nobypass mask", 32'(if_c.free_mask), 32'h2);

        // Freeing slot 3 twice counts it once.
        for (int i = 0; i < 2; i++) begin
            idle();
            free_req[0] = 1; free_idx[0] = 2'd3;
            step();
        end
        check("double free mask", 32'(if_a.free_mask), 32'h8);
        check("double free count", 32'(if_a.free_count), 32'd1);

        // Restore wins over a concurrent alloc and free.
        idle();
        restore_req[0] = 1; rmask[0] = 4'b1010;
        alloc_req[0] = 1; free_req[0] = 1; free_idx[0] = 2'd0;
        step();
        check("restore mask", 32'(if_a.free_mask), 32'ha);
        check("restore count", 32'(if_a.free_count), 32'd2);

        // Reset mid-stream after three allocs, with a free pending.
        idle();
        reset = 1;
        step();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            idle();
            alloc_req[0] = 1;
            step();
        end
        check("three allocs count", 32'(if_a.free_count), 32'd1);
        idle();
        reset = 1; free_req[0] = 1; free_idx[0] = 2'd0; alloc_req[0] = 1;
        step();
        reset = 0;
        check("midstream reset mask", 32'(if_a.free_mask), 32'hf);
        check("midstream reset count", 32'(if_a.free_count), 32'd4);

        // Random traffic against the reference sets.
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            for (int k = 0; k < 3; k++) begin
                alloc_req[k]   = $urandom_range(0, 1) == 1;
                free_req[k]    = $urandom_range(0, 2) == 0;
                free_idx[k]    = 2'($urandom_range(0, 3));
                restore_req[k] = $urandom_range(0, 19) == 0;
                rmask[k]       = 4'($urandom_range(0, 15));
            end
            step();
        end
        reset = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
